// File: rtl/km_loader_pkg.sv
// Shared constants and types for the kernel-memory loader.
// KM_DEPTH : coefficient / memory word width in bits (multiple of 8)
// KM_AW    : kernel-memory address width
// KM_WORDS : number of kernel-memory locations (2**KM_AW)
package km_loader_pkg;

  localparam int KM_DEPTH = 16;
  localparam int KM_AW    = 5;
  localparam int KM_WORDS = 2 ** KM_AW;

  // Largest legal load length, sized to the KML_LEN port.
  localparam logic [KM_AW:0] KM_LEN_MAX = (KM_AW + 1)'(KM_WORDS);

  typedef enum logic [1:0] {
    KML_IDLE = 2'd0,
    KML_LOAD = 2'd1,
    KML_FIN  = 2'd2
  } kml_state_t;

  function automatic logic len_legal(input logic [KM_AW:0] len);
    return (len != '0) && (len <= KM_LEN_MAX);
  endfunction

endpackage

// File: rtl/km_loader.sv
// Kernel-memory loader: takes coefficients from a valid/ready stream and
// writes them to consecutive kernel-memory locations starting at KML_BASE.
// Ports:
//   KML_CLK, KML_RST        clock, synchronous active-high reset
//   KML_START/BASE/LEN      load request (sampled only when idle)
//   S_VALID/S_DATA/S_READY  coefficient stream
//   KM_WE/KM_ADDR/KM_DIN    registered kernel-memory write port
//   KML_BUSY                load in progress, kernel reads invalid
//   KML_DONE                one-cycle pulse alongside the final write
//   KML_ERR                 one-cycle pulse for a rejected (bad length) start
//
// state | meaning
// IDLE  | waiting for START; BUSY low
// LOAD  | S_READY high, one write per accepted word
// FIN   | final write presented, DONE pulses, BUSY still high
module km_loader
  import km_loader_pkg::*;
(
  input  logic                KML_CLK,
  input  logic                KML_RST,
  input  logic                KML_START,
  input  logic [KM_AW-1:0]    KML_BASE,
  input  logic [KM_AW:0]      KML_LEN,
  input  logic                S_VALID,
  input  logic [KM_DEPTH-1:0] S_DATA,
  output logic                S_READY,
  output logic                KM_WE,
  output logic [KM_AW-1:0]    KM_ADDR,
  output logic [KM_DEPTH-1:0] KM_DIN,
  output logic                KML_BUSY,
  output logic                KML_DONE,
  output logic                KML_ERR
);

  kml_state_t r_state;
  kml_state_t w_state_nxt;

  logic [KM_AW-1:0]    r_addr;
  logic [KM_AW:0]      r_rem;
  logic                r_km_we;
  logic [KM_AW-1:0]    r_km_addr;
  logic [KM_DEPTH-1:0] r_km_din;
  logic                r_err;

  logic w_start;
  logic w_start_ok;
  logic w_start_bad;
  logic w_hs;
  logic w_last;

  assign w_start     = KML_START && (r_state == KML_IDLE);
  assign w_start_ok  = w_start && len_legal(KML_LEN);
  assign w_start_bad = w_start && !len_legal(KML_LEN);
  assign w_hs        = S_VALID && S_READY;
  assign w_last      = (r_rem == (KM_AW + 1)'(1));

  always_ff @(posedge KML_CLK) begin
    if (KML_RST) r_state <= KML_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    S_READY     = 1'b0;
    KML_BUSY    = 1'b0;
    KML_DONE    = 1'b0;
    case (r_state)
      KML_IDLE: begin
        if (w_start_ok) w_state_nxt = KML_LOAD;
      end
      KML_LOAD: begin
        S_READY  = 1'b1;
        KML_BUSY = 1'b1;
        if (S_VALID && w_last) w_state_nxt = KML_FIN;
      end
      KML_FIN: begin
        // The last write is on the port this cycle; memory is final next cycle.
        KML_BUSY    = 1'b1;
        KML_DONE    = 1'b1;
        w_state_nxt = KML_IDLE;
      end
      default: w_state_nxt = KML_IDLE;
    endcase
  end

  always_ff @(posedge KML_CLK) begin
    if (KML_RST) begin
      r_addr    <= '0;
      r_rem     <= '0;
      r_km_we   <= 1'b0;
      r_km_addr <= '0;
      r_km_din  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_km_we <= w_hs;
      r_err   <= w_start_bad;
      if (w_start_ok) begin
        r_addr <= KML_BASE;
        r_rem  <= KML_LEN;
      end else if (w_hs) begin
        // Address wraps naturally at KM_WORDS.
        r_km_addr <= r_addr;
        r_km_din  <= S_DATA;
        r_addr    <= r_addr + KM_AW'(1);
        r_rem     <= r_rem - (KM_AW + 1)'(1);
      end
    end
  end

  assign KM_WE   = r_km_we;
  assign KM_ADDR = r_km_addr;
  assign KM_DIN  = r_km_din;
  assign KML_ERR = r_err;

endmodule

// File: tb/tb_km_loader.sv
module tb_km_loader;
  import km_loader_pkg::*;

  logic                clk = 1'b0;
  logic                rst, start, valid;
  logic [KM_AW-1:0]    base;
  logic [KM_AW:0]      len;
  logic [KM_DEPTH-1:0] sdata;
  logic                s_ready, km_we, busy, done, err;
  logic [KM_AW-1:0]    km_addr;
  logic [KM_DEPTH-1:0] km_din;

  always #5 clk = ~clk;

  km_loader dut (
    .KML_CLK(clk), .KML_RST(rst), .KML_START(start), .KML_BASE(base), .KML_LEN(len),
    .S_VALID(valid), .S_DATA(sdata), .S_READY(s_ready),
    .KM_WE(km_we), .KM_ADDR(km_addr), .KM_DIN(km_din),
    .KML_BUSY(busy), .KML_DONE(done), .KML_ERR(err)
  );

  // Kernel memory stand-in plus event counters, sampled mid-cycle.
  logic [KM_DEPTH-1:0] mem [KM_WORDS];
  int wr_cnt = 0, done_cnt = 0, err_cnt = 0;
  always @(negedge clk) begin
    if (km_we) begin
      mem[km_addr] = km_din;
      wr_cnt++;
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         base;
    int         len;
    int         mode;   // 0 valid held, 1 random valid, 2 valid from pat
    logic [7:0] pat;
    bit         mid;    // pulse START again mid-load
    int         dkind;  // 0 random, 1 0x11*(i+1), 2 0xA0+i
    bit         exp_err;
    int         exp_wr;
  } vec_t;

  logic [KM_DEPTH-1:0] dbuf [KM_WORDS];

  // Cycle-by-cycle model: the loader must accept exactly len words while
  // ready, present each one a cycle later at base+i mod 32, and pulse DONE
  // with the final write.
  task automatic run_load(input int b, input int l, input int mode, input logic [7:0] pat,
                          input bit mid, output int cyc_done);
    int k;
    bit prev_hs, legal, v, hs, rdy;
    k = 0;
    prev_hs = 0;
    cyc_done = -1;
    legal = (l >= 1) && (l <= KM_WORDS);
    start = 1; base = b[KM_AW-1:0]; len = l[KM_AW:0];
    step();
    start = 0;
    if (!legal) begin
      check("err_pulse", err, 1);
      check("err_busy", busy, 0);
      check("err_ready", s_ready, 0);
      step();
      check("err_width", err, 0);
      check("err_busy2", busy, 0);
      step();
      return;
    end
    for (int cyc = 1; cyc <= 400; cyc++) begin
      rdy = (k < l);
      check("ready", s_ready, rdy);
      check("busy", busy, 1);
      check("we", km_we, prev_hs);
      if (prev_hs) begin
        check("addr", km_addr, (b + k - 1) % KM_WORDS);
        check("din", km_din, dbuf[k-1]);
      end
      check("done", done, prev_hs && (k == l));
      if (k == l) begin
        cyc_done = cyc;
        step();
        check("busy_fall", busy, 0);
        check("done_width", done, 0);
        check("we_after", km_we, 0);
        break;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = 1'($urandom_range(0, 1));
        default: v = pat[(cyc - 1) % 8];
      endcase
      valid = v;
      sdata = v ? dbuf[k] : KM_DEPTH'($urandom);
      if (mid && cyc == 3) begin
        start = 1; base = KM_AW'($urandom); len = '0;
      end
      hs = v && rdy;
      step();
      start = 0;
      valid = 0;
      if (hs) k++;
      prev_hs = hs;
    end
    check("load_completed", cyc_done > 0, 1);
  endtask

  task automatic do_case(input vec_t t);
    int w0, d0, e0, cd, mism;
    for (int i = 0; i < KM_WORDS; i++) begin
      case (t.dkind)
        1:       dbuf[i] = KM_DEPTH'(16'h0011 * (i + 1));
        2:       dbuf[i] = KM_DEPTH'(16'h00A0 + i);
        default: dbuf[i] = KM_DEPTH'($urandom);
      endcase
    end
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    run_load(t.base, t.len, t.mode, t.pat, t.mid, cd);
    check("err_count", err_cnt - e0, t.exp_err ? 1 : 0);
    check("write_count", wr_cnt - w0, t.exp_wr);
    check("done_count", done_cnt - d0, t.exp_err ? 0 : 1);
    if (!t.exp_err) begin
      mism = 0;
      for (int i = 0; i < t.len; i++)
        if (mem[(t.base + i) % KM_WORDS] !== dbuf[i]) mism++;
      check("mem_content", mism, 0);
      if (t.mode == 0) check("start_to_done", cd, t.len + 1);
    end
  endtask

  vec_t tbl[8];
  vec_t rv;
  int   w0, d0, e0, b0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{base:0,  len:4,  mode:0, pat:8'h00,         mid:0, dkind:1, exp_err:0, exp_wr:4};
    tbl[1] = '{base:30, len:4,  mode:0, pat:8'h00,         mid:0, dkind:2, exp_err:0, exp_wr:4};
    tbl[2] = '{base:7,  len:3,  mode:2, pat:8'b0010_1001, mid:0, dkind:0, exp_err:0, exp_wr:3};
    tbl[3] = '{base:3,  len:0,  mode:0, pat:8'h00,         mid:0, dkind:0, exp_err:1, exp_wr:0};
    tbl[4] = '{base:3,  len:33, mode:0, pat:8'h00,         mid:0, dkind:0, exp_err:1, exp_wr:0};
    tbl[5] = '{base:12, len:8,  mode:0, pat:8'h00,         mid:1, dkind:0, exp_err:0, exp_wr:8};
    tbl[6] = '{base:17, len:32, mode:1, pat:8'h00,         mid:0, dkind:0, exp_err:0, exp_wr:32};
    tbl[7] = '{base:31, len:1,  mode:0, pat:8'h00,         mid:0, dkind:0, exp_err:0, exp_wr:1};

    rst = 1; start = 0; valid = 0; base = '0; len = '0; sdata = '0;
    step();
    step();
    check("rst_ready", s_ready, 0);
    check("rst_we", km_we, 0);
    check("rst_addr", km_addr, 0);
    check("rst_din", km_din, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 0;
    step();

    foreach (tbl[i]) do_case(tbl[i]);

    // Randomized loads, including illegal lengths.
    for (int n = 0; n < 16; n++) begin
      rv.base = $urandom_range(0, KM_WORDS - 1);
      rv.len  = $urandom_range(0, KM_WORDS + 2);
      rv.mode = $urandom_range(0, 1);
      rv.pat = 8'h00; rv.mid = 0; rv.dkind = 0;
      rv.exp_err = (rv.len < 1) || (rv.len > KM_WORDS);
      rv.exp_wr  = rv.exp_err ? 0 : rv.len;
      do_case(rv);
    end

    // Reset after 2 of 6 words: load abandoned, first two words kept.
    b0 = $urandom_range(0, KM_WORDS - 1);
    dbuf[0] = 16'h5A01; dbuf[1] = 16'h5A02;
    w0 = wr_cnt; d0 = done_cnt;
    start = 1; base = b0[KM_AW-1:0]; len = 6'd6;
    step();
    start = 0;
    valid = 1; sdata = dbuf[0];
    step();
    sdata = dbuf[1];
    step();
    valid = 0; rst = 1;
    step();
    rst = 0;
    check("rstmid_busy", busy, 0);
    check("rstmid_ready", s_ready, 0);
    check("rstmid_we", km_we, 0);
    step();
    check("rstmid_done", done_cnt - d0, 0);
    check("rstmid_writes", wr_cnt - w0, 2);
    check("rstmid_mem0", mem[b0 % KM_WORDS], dbuf[0]);
    check("rstmid_mem1", mem[(b0 + 1) % KM_WORDS], dbuf[1]);

    // START together with reset: reset wins, no load and no error.
    e0 = err_cnt;
    rst = 1; start = 1; len = 6'd4; base = 5'd9;
    step();
    rst = 0; start = 0;
    check("rststart_busy", busy, 0);
    check("rststart_ready", s_ready, 0);
    rst = 1; start = 1; len = '0;
    step();
    rst = 0; start = 0;
    step();
    check("rststart_err", err_cnt - e0, 0);
    check("rststart_busy2", busy, 0);

    // Loader still works after the abandoned load.
    rv = '{base:5, len:5, mode:0, pat:8'h00, mid:0, dkind:0, exp_err:0, exp_wr:5};
    do_case(rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
